// File: rtl/fpu_fp16_to_int.sv
// Iterative FP16 -> integer converter: one shift step per cycle, then RNE rounding and saturation.
// Valid/ready on both sides; a single conversion is in flight at a time.
package fpu_fp16_to_int_pkg;
   typedef struct packed {
      logic       sign;
      logic [4:0] exp;
      logic [9:0] frac;
   } fp16_t;

   typedef struct packed {
      logic of;
      logic uf;
      logic nx;
   } opStatusFlag_t;
endpackage

module fpu_fp16_to_int
   import fpu_fp16_to_int_pkg::*;
#(
   parameter int INTW   = 16,
   parameter bit SIGNED = 1'b1
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            inValid,
   output logic            inReady,
   input  fp16_t           fpIn,
   output logic            outValid,
   input  logic            outReady,
   output logic [INTW-1:0] intOut,
   output opStatusFlag_t   opStatusFlags
);

   // The accumulator must hold the full 11-bit significand even for narrow results.
   localparam int AW = (INTW > 11) ? INTW : 11;
   localparam int MW = AW + 1;

   localparam logic [INTW-1:0] SAT_MAX = SIGNED ? {1'b0, {(INTW-1){1'b1}}} : {INTW{1'b1}};
   localparam logic [INTW-1:0] SAT_MIN = SIGNED ? {1'b1, {(INTW-1){1'b0}}} : {INTW{1'b0}};
   localparam logic [MW-1:0]   LIM_POS = {{(MW-INTW+1){1'b0}}, {(INTW-1){1'b1}}};
   localparam logic [MW-1:0]   LIM_NEG = {{(MW-INTW){1'b0}}, 1'b1, {(INTW-1){1'b0}}};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_ROUND = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [AW-1:0]       acc_q, acc_d;
   logic signed [5:0]   cnt_q, cnt_d;
   logic                guard_q, guard_d;
   logic                sticky_q, sticky_d;
   logic                ovf_q, ovf_d;
   logic                sign_q, sign_d;
   logic [INTW-1:0]     result_q, result_d;
   opStatusFlag_t       flags_q, flags_d;
   logic                out_valid_q, out_valid_d;

   logic [4:0]          e_eff_s;
   logic signed [5:0]   cnt_init_s;
   logic                inc_s;
   logic [MW-1:0]       mag_s;
   logic                big_s;
   logic                nx_s;

   assign e_eff_s    = (fpIn.exp == 5'd0) ? 5'd1 : fpIn.exp;
   assign cnt_init_s = $signed({1'b0, e_eff_s}) - 6'sd25;

   assign inc_s = guard_q & (sticky_q | acc_q[0]);
   assign mag_s = {1'b0, acc_q} + {{AW{1'b0}}, inc_s};
   assign big_s = ovf_q | (|mag_s[MW-1:INTW]);
   assign nx_s  = guard_q | sticky_q;

   assign inReady       = (state_q == ST_IDLE) && !reset;
   assign outValid      = out_valid_q;
   assign intOut        = result_q;
   assign opStatusFlags = flags_q;

   // Next-state, datapath step and result formation.
   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      guard_d     = guard_q;
      sticky_d    = sticky_q;
      ovf_d       = ovf_q;
      sign_d      = sign_q;
      result_d    = result_q;
      flags_d     = flags_q;
      out_valid_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (inValid) begin
               sign_d   = fpIn.sign;
               guard_d  = 1'b0;
               sticky_d = 1'b0;
               ovf_d    = 1'b0;
               if (fpIn.exp == 5'h1F) begin
                  result_d   = (fpIn.sign && (fpIn.frac == 10'd0)) ? SAT_MIN : SAT_MAX;
                  flags_d    = '0;
                  flags_d.of = 1'b1;
                  state_d    = ST_DONE;
               end else if ((fpIn.exp == 5'd0) && (fpIn.frac == 10'd0)) begin
                  result_d = '0;
                  flags_d  = '0;
                  state_d  = ST_DONE;
               end else begin
                  acc_d       = '0;
                  acc_d[10:0] = {(fpIn.exp != 5'd0), fpIn.frac};
                  cnt_d       = cnt_init_s;
                  state_d     = (cnt_init_s == 6'sd0) ? ST_ROUND : ST_SHIFT;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_SHIFT: begin
            if (cnt_q > 6'sd0) begin
               ovf_d = ovf_q | acc_q[AW-1];
               acc_d = {acc_q[AW-2:0], 1'b0};
               cnt_d = cnt_q - 6'sd1;
            end else begin
               sticky_d = sticky_q | guard_q;
               guard_d  = acc_q[0];
               acc_d    = {1'b0, acc_q[AW-1:1]};
               cnt_d    = cnt_q + 6'sd1;
            end
            if (cnt_d == 6'sd0) begin
               state_d = ST_ROUND;
            end else begin
               state_d = ST_SHIFT;
            end
         end

         ST_ROUND: begin
            state_d    = ST_DONE;
            flags_d    = '0;
            flags_d.nx = nx_s;
            if (SIGNED) begin
               if (!sign_q && (big_s || (mag_s > LIM_POS))) begin
                  result_d = SAT_MAX;
                  flags_d  = '0;
                  flags_d.of = 1'b1;
               end else if (sign_q && (big_s || (mag_s > LIM_NEG))) begin
                  result_d = SAT_MIN;
                  flags_d  = '0;
                  flags_d.of = 1'b1;
               end else begin
                  result_d = sign_q ? -mag_s[INTW-1:0] : mag_s[INTW-1:0];
               end
            end else begin
               // A negative input clamps to zero even when its magnitude also overflows.
               if (sign_q && (mag_s != '0)) begin
                  result_d = SAT_MIN;
                  flags_d  = '0;
                  flags_d.of = 1'b1;
               end else if (big_s) begin
                  result_d = SAT_MAX;
                  flags_d  = '0;
                  flags_d.of = 1'b1;
               end else begin
                  result_d = sign_q ? {INTW{1'b0}} : mag_s[INTW-1:0];
               end
            end
         end

         ST_DONE: begin
            out_valid_d = 1'b1;
            if (out_valid_q && outReady) begin
               out_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end else begin
               state_d = ST_DONE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         acc_q       <= '0;
         cnt_q       <= 6'sd0;
         guard_q     <= 1'b0;
         sticky_q    <= 1'b0;
         ovf_q       <= 1'b0;
         sign_q      <= 1'b0;
         result_q    <= '0;
         flags_q     <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         guard_q     <= guard_d;
         sticky_q    <= sticky_d;
         ovf_q       <= ovf_d;
         sign_q      <= sign_d;
         result_q    <= result_d;
         flags_q     <= flags_d;
         out_valid_q <= out_valid_d;
      end
   end

endmodule

// File: tb/tb_fpu_fp16_to_int.sv
// Bench for fpu_fp16_to_int: signed and unsigned instances driven in lockstep,
// directed vector table, random operands against an arithmetic model, backpressure and reset abort.
module tb_fpu_fp16_to_int;
   import fpu_fp16_to_int_pkg::*;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          in_valid = 1'b0;
   logic          out_ready = 1'b1;
   fp16_t         fp_in = '0;
   logic          in_ready_s, in_ready_u, out_valid_s, out_valid_u;
   logic [15:0]   int_s, int_u;
   opStatusFlag_t fl_s, fl_u;

   int total = 0;
   int bad   = 0;

   fpu_fp16_to_int #(.INTW(16), .SIGNED(1'b1)) dut_s (
      .clock(clock), .reset(reset), .inValid(in_valid), .inReady(in_ready_s),
      .fpIn(fp_in), .outValid(out_valid_s), .outReady(out_ready),
      .intOut(int_s), .opStatusFlags(fl_s)
   );

   fpu_fp16_to_int #(.INTW(16), .SIGNED(1'b0)) dut_u (
      .clock(clock), .reset(reset), .inValid(in_valid), .inReady(in_ready_u),
      .fpIn(fp_in), .outValid(out_valid_u), .outReady(out_ready),
      .intOut(int_u), .opStatusFlags(fl_u)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [15:0] fp;
      logic [15:0] vs;
      logic [2:0]  fs;
      logic [15:0] vu;
      logic [2:0]  fu;
      int          lat;
   } vec_t;

   vec_t vecs[17];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   // Value-level reference: x = sig * 2^(eEff-25), rounded to nearest even, then clamped.
   function automatic void model(input logic [15:0] x, input bit sgn_mode,
                                 output logic [15:0] v, output logic [2:0] f);
      bit     s;
      int     e, fr, eff, sh;
      longint sig, mag, rem, half;
      bit     nx;
      s  = x[15];
      e  = int'(x[14:10]);
      fr = int'(x[9:0]);
      v  = 16'h0000;
      f  = 3'b000;
      nx = 1'b0;
      if (e == 31) begin
         f = 3'b100;
         if (sgn_mode) v = (s && fr == 0) ? 16'h8000 : 16'h7FFF;
         else          v = (s && fr == 0) ? 16'h0000 : 16'hFFFF;
         return;
      end
      if (e == 0 && fr == 0) return;
      sig = (e != 0) ? longint'(1024 + fr) : longint'(fr);
      eff = (e == 0) ? 1 : e;
      sh  = eff - 25;
      if (sh >= 0) begin
         mag = sig << sh;
      end else begin
         rem  = sig % (longint'(1) << (-sh));
         half = longint'(1) << (-sh - 1);
         mag  = sig >> (-sh);
         nx   = (rem != 0);
         if (rem > half || (rem == half && (mag % 2) == 1)) mag = mag + 1;
      end
      if (sgn_mode) begin
         if (!s && mag > 32767)     begin v = 16'h7FFF; f = 3'b100; end
         else if (s && mag > 32768) begin v = 16'h8000; f = 3'b100; end
         else begin v = s ? 16'(-mag) : 16'(mag); f = {2'b00, nx}; end
      end else begin
         if (s && mag != 0)         begin v = 16'h0000; f = 3'b100; end
         else if (mag > 65535)      begin v = 16'hFFFF; f = 3'b100; end
         else begin v = s ? 16'h0000 : 16'(mag); f = {2'b00, nx}; end
      end
   endfunction

   function automatic int model_lat(input logic [15:0] x);
      int e, eff, d;
      e = int'(x[14:10]);
      if (e == 31 || x[14:0] == 15'd0) return 1;
      eff = (e == 0) ? 1 : e;
      d   = eff - 25;
      return ((d < 0) ? -d : d) + 2;
   endfunction

   task automatic apply(input logic [15:0] x, input logic [15:0] vs, input logic [2:0] fs,
                        input logic [15:0] vu, input logic [2:0] fu, input int lat_exp,
                        input string tag);
      int n;
      int lat;
      n = 0;
      while (!(in_ready_s && in_ready_u) && n < 40) begin
         @(posedge clock); #1;
         n++;
      end
      check({tag, " inReady"}, {31'd0, in_ready_s & in_ready_u}, 32'd1);
      fp_in    = fp16_t'(x);
      in_valid = 1'b1;
      @(posedge clock); #1;
      in_valid = 1'b0;
      fp_in    = fp16_t'(16'($urandom));
      lat = 0;
      while (!out_valid_s && lat < 40) begin
         @(posedge clock); #1;
         lat++;
      end
      check({tag, " latency"}, 32'(lat), 32'(lat_exp));
      check({tag, " uns outValid"}, {31'd0, out_valid_u}, 32'd1);
      check({tag, " s intOut"}, {16'd0, int_s}, {16'd0, vs});
      check({tag, " s flags"}, {29'd0, fl_s}, {29'd0, fs});
      check({tag, " u intOut"}, {16'd0, int_u}, {16'd0, vu});
      check({tag, " u flags"}, {29'd0, fl_u}, {29'd0, fu});
      if (out_ready) begin
         @(posedge clock); #1;
      end
   endtask

   initial begin
      logic [15:0] x, vs, vu;
      logic [2:0]  fs, fu;
      int          n;

      vecs[0]  = '{16'h3C00, 16'h0001, 3'b000, 16'h0001, 3'b000, 12};
      vecs[1]  = '{16'h4100, 16'h0002, 3'b001, 16'h0002, 3'b001, 11};
      vecs[2]  = '{16'h4300, 16'h0004, 3'b001, 16'h0004, 3'b001, 11};
      vecs[3]  = '{16'hB800, 16'h0000, 3'b001, 16'h0000, 3'b001, 13};
      vecs[4]  = '{16'hF800, 16'h8000, 3'b000, 16'h0000, 3'b100, 7};
      vecs[5]  = '{16'h7800, 16'h7FFF, 3'b100, 16'h8000, 3'b000, 7};
      vecs[6]  = '{16'hFBFF, 16'h8000, 3'b100, 16'h0000, 3'b100, 7};
      vecs[7]  = '{16'h7E00, 16'h7FFF, 3'b100, 16'hFFFF, 3'b100, 1};
      vecs[8]  = '{16'hFC00, 16'h8000, 3'b100, 16'h0000, 3'b100, 1};
      vecs[9]  = '{16'h8000, 16'h0000, 3'b000, 16'h0000, 3'b000, 1};
      vecs[10] = '{16'h0001, 16'h0000, 3'b001, 16'h0000, 3'b001, 26};
      vecs[11] = '{16'hBC00, 16'hFFFF, 3'b000, 16'h0000, 3'b100, 12};
      vecs[12] = '{16'h7BFF, 16'h7FFF, 3'b100, 16'hFFE0, 3'b000, 7};
      vecs[13] = '{16'h7C00, 16'h7FFF, 3'b100, 16'hFFFF, 3'b100, 1};
      vecs[14] = '{16'h3800, 16'h0000, 3'b001, 16'h0000, 3'b001, 13};
      vecs[15] = '{16'h3E00, 16'h0002, 3'b001, 16'h0002, 3'b001, 12};
      vecs[16] = '{16'h0000, 16'h0000, 3'b000, 16'h0000, 3'b000, 1};

      repeat (2) @(posedge clock);
      #1;
      check("reset outValid", {30'd0, out_valid_s, out_valid_u}, 32'd0);
      check("reset intOut", {int_s, int_u}, 32'd0);
      check("reset flags", {26'd0, fl_s, fl_u}, 32'd0);
      check("reset inReady", {30'd0, in_ready_s, in_ready_u}, 32'd0);
      reset = 1'b0;
      #1;
      check("idle inReady", {30'd0, in_ready_s, in_ready_u}, 32'd3);

      for (int i = 0; i < 17; i++) begin
         apply(vecs[i].fp, vecs[i].vs, vecs[i].fs, vecs[i].vu, vecs[i].fu, vecs[i].lat,
               $sformatf("vec%0d", i));
      end

      for (int i = 0; i < 200; i++) begin
         x = 16'($urandom);
         model(x, 1'b1, vs, fs);
         model(x, 1'b0, vu, fu);
         apply(x, vs, fs, vu, fu, model_lat(x), $sformatf("rand %h", x));
      end

      // Backpressure: result must hold while the consumer stalls.
      out_ready = 1'b0;
      apply(16'h4300, 16'h0004, 3'b001, 16'h0004, 3'b001, 11, "bp");
      for (int i = 0; i < 5; i++) begin
         @(posedge clock); #1;
         check("bp outValid", {31'd0, out_valid_s}, 32'd1);
         check("bp intOut", {16'd0, int_s}, 32'd4);
         check("bp flags", {29'd0, fl_s}, 32'd1);
         check("bp inReady", {31'd0, in_ready_s}, 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clock); #1;
      check("bp release outValid", {31'd0, out_valid_s}, 32'd0);
      check("bp release inReady", {31'd0, in_ready_s}, 32'd1);

      // Reset during a long subnormal shift sequence aborts it silently.
      fp_in    = fp16_t'(16'h0001);
      in_valid = 1'b1;
      @(posedge clock); #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clock);
      #1;
      reset = 1'b1;
      @(posedge clock); #1;
      check("abort outValid", {30'd0, out_valid_s, out_valid_u}, 32'd0);
      check("abort inReady in reset", {30'd0, in_ready_s, in_ready_u}, 32'd0);
      reset = 1'b0;
      #1;
      check("abort inReady", {30'd0, in_ready_s, in_ready_u}, 32'd3);
      check("abort intOut", {int_s, int_u}, 32'd0);
      n = 0;
      repeat (30) begin
         @(posedge clock); #1;
         if (out_valid_s || out_valid_u) n++;
      end
      check("abort no result", 32'(n), 32'd0);
      apply(16'h3C00, 16'h0001, 3'b000, 16'h0001, 3'b000, 12, "post abort");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
